// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle between the oam_dma_arbiter and its CPU, PPU, VRAM, OAM and DMA-source neighbours.
// slave is the arbiter's view; master is the surrounding system's view.
interface oam_dma_arbiter_if;
  logic        lcd_on;
  logic [1:0]  ppu_mode;
  logic [15:0] ppu_oam_a;
  logic [15:0] ppu_vram_a;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_din;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic [15:0] oam_a;
  logic [7:0]  oam_din;
  logic        oam_wr;
  logic [7:0]  oam_dout;
  logic [15:0] vram_a;
  logic [7:0]  vram_din;
  logic        vram_wr;
  logic [7:0]  vram_dout;
  logic [15:0] dma_src_a;
  logic        dma_src_rd;
  logic [7:0]  dma_src_dout;
  logic        dma_active;
  logic [7:0]  dma_reg;

  modport slave (
    input  lcd_on, ppu_mode, ppu_oam_a, ppu_vram_a,
    input  cpu_a, cpu_din, cpu_wr, cpu_rd,
    input  oam_dout, vram_dout, dma_src_dout,
    output cpu_dout, oam_a, oam_din, oam_wr,
    output vram_a, vram_din, vram_wr,
    output dma_src_a, dma_src_rd, dma_active, dma_reg
  );

  modport master (
    output lcd_on, ppu_mode, ppu_oam_a, ppu_vram_a,
    output cpu_a, cpu_din, cpu_wr, cpu_rd,
    output oam_dout, vram_dout, dma_src_dout,
    input  cpu_dout, oam_a, oam_din, oam_wr,
    input  vram_a, vram_din, vram_wr,
    input  dma_src_a, dma_src_rd, dma_active, dma_reg
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// VRAM/OAM bus arbiter between CPU, PPU and the FF46 OAM DMA engine.
// Bus muxes are combinational; CPU read data arrives the cycle after cpu_rd.
module oam_dma_arbiter #(
  parameter int DMA_LEN         = 160,
  parameter int DMA_STARTUP     = 4,
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic              clk,
  input  logic              rst,
  oam_dma_arbiter_if.slave  bus
);

  localparam int SUB_W = $clog2(CYCLES_PER_BYTE);
  localparam int CNT_W = (DMA_STARTUP > 1) ? $clog2(DMA_STARTUP) : 1;

  localparam logic [SUB_W-1:0] SUB_RD   = '0;
  localparam logic [SUB_W-1:0] SUB_WR   = SUB_W'(1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_BYTE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMA_STARTUP - 1);
  localparam logic [7:0]       IDX_LAST = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    COPY  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_FF   = 2'd0,
    SRC_OAM  = 2'd1,
    SRC_VRAM = 2'd2,
    SRC_REG  = 2'd3
  } rd_src_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dma_reg_q;
  rd_src_t          rd_src_q, rd_src_d;

  logic cpu_acc;
  logic hit_vram;
  logic hit_oam;
  logic hit_reg;
  logic ff46_wr;
  logic ppu_vram_own;
  logic ppu_oam_own;
  logic dma_own;
  logic cpu_vram_ok;
  logic cpu_oam_ok;
  logic dma_rd;
  logic dma_wr;

  // Address decode and bus ownership
  assign cpu_acc      = bus.cpu_rd | bus.cpu_wr;
  assign hit_vram     = (bus.cpu_a[15:13] == 3'b100);
  assign hit_oam      = (bus.cpu_a[15:8] == 8'hFE) && (bus.cpu_a[7:0] < 8'hA0);
  assign hit_reg      = (bus.cpu_a == 16'hFF46);
  assign ff46_wr      = bus.cpu_wr && hit_reg;

  assign ppu_vram_own = bus.lcd_on && (bus.ppu_mode == 2'd3);
  assign ppu_oam_own  = bus.lcd_on && bus.ppu_mode[1];
  assign dma_own      = (state_q != IDLE);

  assign cpu_vram_ok  = hit_vram && !ppu_vram_own;
  assign cpu_oam_ok   = hit_oam && !dma_own && !ppu_oam_own;

  assign dma_rd       = (state_q == COPY) && (sub_q == SUB_RD);
  assign dma_wr       = (state_q == COPY) && (sub_q == SUB_WR);

  assign bus.dma_active = dma_own;
  assign bus.dma_reg    = dma_reg_q;
  assign bus.dma_src_rd = dma_rd;
  assign bus.dma_src_a  = {dma_reg_q, idx_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sub_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    case (state_q)
      START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = COPY;
          idx_d   = '0;
          sub_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COPY: begin
        // The final byte ends on its write slot; no trailing idle sub-cycles.
        if (sub_q == SUB_WR && idx_q == IDX_LAST) begin
          state_d = IDLE;
        end else if (sub_q == SUB_LAST) begin
          sub_d = '0;
          idx_d = idx_q + 8'd1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A rewrite restarts from START; the write in this cycle is still issued.
    if (ff46_wr) begin
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      sub_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_reg_q <= 8'h00;
    end else if (ff46_wr) begin
      dma_reg_q <= bus.cpu_din;
    end
  end

  always_comb begin
    bus.vram_a   = 16'hFFFF;
    bus.vram_din = 8'h00;
    bus.vram_wr  = 1'b0;
    if (ppu_vram_own) begin
      bus.vram_a = bus.ppu_vram_a;
    end else begin
      bus.vram_din = bus.cpu_din;
      if (cpu_acc && hit_vram) begin
        bus.vram_a  = bus.cpu_a;
        bus.vram_wr = bus.cpu_wr;
      end
    end
  end

  always_comb begin
    bus.oam_a   = 16'hFFFF;
    bus.oam_din = 8'h00;
    bus.oam_wr  = 1'b0;
    if (dma_own) begin
      bus.oam_a   = {8'hFE, idx_q};
      bus.oam_din = bus.dma_src_dout;
      bus.oam_wr  = dma_wr;
    end else if (ppu_oam_own) begin
      bus.oam_a = bus.ppu_oam_a;
    end else begin
      bus.oam_din = bus.cpu_din;
      if (cpu_acc && hit_oam) begin
        bus.oam_a  = bus.cpu_a;
        bus.oam_wr = bus.cpu_wr;
      end
    end
  end

  // Read source is decided on the cpu_rd cycle, so a later ownership change
  // cannot redirect data already fetched by the RAM.
  always_comb begin
    rd_src_d = SRC_FF;
    if (bus.cpu_rd) begin
      if (hit_reg) begin
        rd_src_d = SRC_REG;
      end else if (cpu_vram_ok) begin
        rd_src_d = SRC_VRAM;
      end else if (cpu_oam_ok) begin
        rd_src_d = SRC_OAM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_src_q <= SRC_FF;
    end else begin
      rd_src_q <= rd_src_d;
    end
  end

  always_comb begin
    case (rd_src_q)
      SRC_OAM:  bus.cpu_dout = bus.oam_dout;
      SRC_VRAM: bus.cpu_dout = bus.vram_dout;
      SRC_REG:  bus.cpu_dout = dma_reg_q;
      default:  bus.cpu_dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: directed scenarios then random CPU traffic
// checked against a schedule-level model of DMA timing and bus ownership.
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

  localparam int DMA_LEN = 160;
  localparam int STARTUP = 4;
  localparam int CPB     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oam_dma_arbiter_if bus();

  oam_dma_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          c;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t oam_q[$];
  ev_t vram_q[$];
  ev_t src_q[$];
  ev_t rd_q[$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int act_start  = 0;
  int act_end    = 0;
  bit mon_on     = 1'b0;
  bit rd_pend    = 1'b0;

  logic [7:0] reg_ref;
  logic [7:0] vram_ref [0:8191];
  logic [7:0] oam_ref  [0:159];
  logic [7:0] vram_mem [0:8191];
  logic [7:0] oam_mem  [0:159];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] src_f(input logic [15:0] a);
    return a[7:0] ^ 8'h33 ^ (a[15:8] ^ 8'hC1);
  endfunction

  function automatic bit model_active(input int c);
    return (c >= act_start) && (c < act_end);
  endfunction

  function automatic bit in_vram(input logic [15:0] a);
    return a >= 16'h8000 && a <= 16'h9FFF;
  endfunction

  function automatic bit in_oam(input logic [15:0] a);
    return a >= 16'hFE00 && a <= 16'hFE9F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Environment models: VRAM/OAM with 1-cycle read latency, DMA source as a pure function.
  always @(posedge clk) begin
    if (bus.vram_wr && in_vram(bus.vram_a)) vram_mem[bus.vram_a[12:0]] <= bus.vram_din;
    bus.vram_dout <= in_vram(bus.vram_a) ? vram_mem[bus.vram_a[12:0]] : 8'hFF;
    if (bus.oam_wr && in_oam(bus.oam_a)) oam_mem[bus.oam_a[7:0]] <= bus.oam_din;
    bus.oam_dout <= in_oam(bus.oam_a) ? oam_mem[bus.oam_a[7:0]] : 8'hFF;
    if (bus.dma_src_rd) bus.dma_src_dout <= src_f(bus.dma_src_a);
  end

  // Reference model: a FF46 write at cycle t schedules every source read and OAM write.
  task automatic drop_after(input int c);
    for (int k = oam_q.size() - 1; k >= 0; k--) if (oam_q[k].c > c) oam_q.delete(k);
    for (int k = src_q.size() - 1; k >= 0; k--) if (src_q[k].c > c) src_q.delete(k);
  endtask

  task automatic start_dma(input int t, input logic [7:0] v);
    ev_t e;
    if (!model_active(t)) act_start = t + 1;
    drop_after(t);
    for (int i = 0; i < DMA_LEN; i++) begin
      e.c = t + STARTUP + 1 + CPB * i;
      e.a = {v, 8'(i)};
      e.d = 8'h00;
      src_q.push_back(e);
      e.c = t + STARTUP + 2 + CPB * i;
      e.d = src_f({v, 8'(i)});
      e.a = 16'hFE00 + 16'(i);
      oam_q.push_back(e);
    end
    act_end = t + STARTUP + 3 + CPB * (DMA_LEN - 1);
    reg_ref = v;
  endtask

  task automatic cpu_op(input bit wr, input logic [15:0] a, input logic [7:0] d);
    int c;
    bit vram_ok;
    bit oam_ok;
    ev_t e;
    c = cyc;
    bus.cpu_a   = a;
    bus.cpu_din = d;
    bus.cpu_wr  = wr;
    bus.cpu_rd  = !wr;
    vram_ok = !(bus.lcd_on && bus.ppu_mode == 2'd3);
    oam_ok  = !model_active(c) && !(bus.lcd_on && bus.ppu_mode >= 2'd2);
    e.c = c;
    e.a = a;
    e.d = d;
    if (wr) begin
      if (a == 16'hFF46) start_dma(c, d);
      else if (in_vram(a) && vram_ok) begin
        vram_q.push_back(e);
        vram_ref[a[12:0]] = d;
      end else if (in_oam(a) && oam_ok) begin
        oam_q.push_back(e);
        oam_ref[a[7:0]] = d;
      end
    end else begin
      e.c = c + 1;
      e.d = 8'hFF;
      if (a == 16'hFF46) e.d = reg_ref;
      else if (in_vram(a) && vram_ok) e.d = vram_ref[a[12:0]];
      else if (in_oam(a) && oam_ok) e.d = oam_ref[a[7:0]];
      rd_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    bus.cpu_a  = 16'h0000;
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_pulse();
    int c;
    c = cyc;
    rst = 1'b1;
    drop_after(c);
    if (act_end > c + 1) act_end = c + 1;
    reg_ref = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, source read or read data.
  always @(negedge clk) begin
    ev_t e;
    logic [15:0] va;
    logic [15:0] oa;
    if (mon_on) begin
      chk("dma_active", 64'(bus.dma_active), 64'(model_active(cyc)));

      va = 16'hFFFF;
      if (bus.lcd_on && bus.ppu_mode == 2'd3) va = bus.ppu_vram_a;
      else if ((bus.cpu_rd || bus.cpu_wr) && in_vram(bus.cpu_a)) va = bus.cpu_a;
      chk("vram_a", 64'(bus.vram_a), 64'(va));

      if (!model_active(cyc)) begin
        oa = 16'hFFFF;
        if (bus.lcd_on && bus.ppu_mode >= 2'd2) oa = bus.ppu_oam_a;
        else if ((bus.cpu_rd || bus.cpu_wr) && in_oam(bus.cpu_a)) oa = bus.cpu_a;
        chk("oam_a", 64'(bus.oam_a), 64'(oa));
      end

      if (bus.oam_wr) begin
        if (oam_q.size() == 0) chk("oam_wr_unexpected", 64'({bus.oam_a, bus.oam_din}), 64'hFFFF_FFFF_FFFF);
        else begin
          e = oam_q.pop_front();
          chk("oam_write", 64'({16'(cyc), bus.oam_a, bus.oam_din}), 64'({16'(e.c), e.a, e.d}));
          oam_ref[e.a[7:0]] = e.d;
        end
      end

      if (bus.vram_wr) begin
        if (vram_q.size() == 0) chk("vram_wr_unexpected", 64'({bus.vram_a, bus.vram_din}), 64'hFFFF_FFFF_FFFF);
        else begin
          e = vram_q.pop_front();
          chk("vram_write", 64'({16'(cyc), bus.vram_a, bus.vram_din}), 64'({16'(e.c), e.a, e.d}));
        end
      end

      if (bus.dma_src_rd) begin
        if (src_q.size() == 0) chk("src_rd_unexpected", 64'(bus.dma_src_a), 64'hFFFF_FFFF_FFFF);
        else begin
          e = src_q.pop_front();
          chk("src_read", 64'({16'(cyc), bus.dma_src_a}), 64'({16'(e.c), e.a}));
        end
      end

      if (rd_pend) begin
        if (rd_q.size() == 0) chk("cpu_rd_unexpected", 64'(bus.cpu_dout), 64'hFFFF_FFFF_FFFF);
        else begin
          e = rd_q.pop_front();
          chk($sformatf("cpu_dout@%h", e.a), 64'({16'(cyc), bus.cpu_dout}), 64'({16'(e.c), e.d}));
        end
      end
      rd_pend = bus.cpu_rd;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      bus.ppu_vram_a = 16'h8000 + 16'($urandom_range(0, 8191));
      bus.ppu_oam_a  = 16'hFE00 + 16'($urandom_range(0, 159));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int sel;
    bit wr;
    logic [15:0] a;
    logic [7:0]  d;

    for (int i = 0; i < 8192; i++) begin
      vram_mem[i] = 8'h00;
      vram_ref[i] = 8'h00;
    end
    for (int i = 0; i < 160; i++) begin
      oam_mem[i] = 8'h00;
      oam_ref[i] = 8'h00;
    end
    reg_ref          = 8'h00;
    bus.lcd_on       = 1'b0;
    bus.ppu_mode     = 2'd0;
    bus.ppu_oam_a    = 16'hFE00;
    bus.ppu_vram_a   = 16'h8000;
    bus.cpu_a        = 16'h0000;
    bus.cpu_din      = 8'h00;
    bus.cpu_wr       = 1'b0;
    bus.cpu_rd       = 1'b0;
    bus.oam_dout     = 8'h00;
    bus.vram_dout    = 8'h00;
    bus.dma_src_dout = 8'h00;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;

    chk("reset_dma_reg", 64'(bus.dma_reg), 64'h00);
    chk("reset_cpu_dout", 64'(bus.cpu_dout), 64'hFF);
    chk("reset_dma_active", 64'(bus.dma_active), 64'h0);
    chk("reset_oam_wr", 64'(bus.oam_wr), 64'h0);
    chk("reset_vram_wr", 64'(bus.vram_wr), 64'h0);
    chk("reset_src_rd", 64'(bus.dma_src_rd), 64'h0);

    // CPU owns VRAM with the LCD off.
    cpu_op(1'b1, 16'h8010, 8'h5A);
    cpu_op(1'b0, 16'h8010, 8'h00);

    // PPU mode 3 blocks the CPU from both buses; mode 0 frees them.
    bus.lcd_on = 1'b1;
    bus.ppu_mode = 2'd3;
    cpu_op(1'b0, 16'h9000, 8'h00);
    cpu_op(1'b1, 16'hFE00, 8'h77);
    cpu_op(1'b1, 16'h9000, 8'h11);
    bus.ppu_mode = 2'd0;
    cpu_op(1'b1, 16'h9000, 8'h3C);
    cpu_op(1'b0, 16'h9000, 8'h00);
    cpu_op(1'b1, 16'hFE00, 8'h77);
    cpu_op(1'b0, 16'hFE00, 8'h00);
    cpu_op(1'b0, 16'hFEB0, 8'h00);
    cpu_op(1'b1, 16'hFEB0, 8'h42);
    bus.lcd_on = 1'b0;

    // Full DMA from page C1, with blocked OAM traffic and a free VRAM write mid-copy.
    t = cyc;
    cpu_op(1'b1, 16'hFF46, 8'hC1);
    goto(t + 300);
    cpu_op(1'b0, 16'hFE10, 8'h00);
    cpu_op(1'b1, 16'hFE20, 8'h55);
    cpu_op(1'b1, 16'h8020, 8'h99);
    cpu_op(1'b0, 16'h8020, 8'h00);
    goto(t + 650);
    cpu_op(1'b0, 16'hFF46, 8'h00);
    cpu_op(1'b0, 16'hFE9F, 8'h00);
    cpu_op(1'b0, 16'hFE00, 8'h00);
    cpu_op(1'b0, 16'hFE20, 8'h00);

    // Rewrite FF46 on the cycle of byte 50's OAM write.
    t = cyc;
    cpu_op(1'b1, 16'hFF46, 8'hC2);
    goto(t + STARTUP + 2 + CPB * 50);
    t = cyc;
    cpu_op(1'b1, 16'hFF46, 8'hD0);
    goto(t + 650);
    cpu_op(1'b0, 16'hFF46, 8'h00);
    cpu_op(1'b0, 16'hFE31, 8'h00);

    // Reset in the middle of a copy.
    t = cyc;
    cpu_op(1'b1, 16'hFF46, 8'h7E);
    goto(t + 101);
    reset_pulse();
    goto(cyc + 40);
    cpu_op(1'b0, 16'hFF46, 8'h00);

    // Random CPU traffic across all regions with changing PPU modes.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.lcd_on   = 1'($urandom_range(0, 1));
        bus.ppu_mode = 2'($urandom_range(0, 3));
      end
      sel = int'($urandom_range(0, 39));
      if (sel == 0)      a = 16'hFF46;
      else if (sel < 14) a = 16'h8000 + 16'($urandom_range(0, 63));
      else if (sel < 28) a = 16'hFE00 + 16'($urandom_range(0, 159));
      else if (sel < 33) a = 16'hFEA0 + 16'($urandom_range(0, 95));
      else if (sel < 36) a = 16'hC000 + 16'($urandom_range(0, 255));
      else               a = 16'h9FC0 + 16'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      d  = (a == 16'hFF46) ? 8'($urandom_range(8'h80, 8'hDF)) : 8'($urandom);
      cpu_op(wr, a, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    goto(act_end + 5);
    bus.lcd_on = 1'b0;
    for (int i = 0; i < 160; i += 37) cpu_op(1'b0, 16'hFE00 + 16'(i), 8'h00);
    goto(cyc + 4);

    chk("oam_q_drained", 64'(oam_q.size()), 64'd0);
    chk("vram_q_drained", 64'(vram_q.size()), 64'd0);
    chk("src_q_drained", 64'(src_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Owns the VRAM (0x8000-0x9FFF) and OAM (0xFE00-0xFE9F) buses and shares them between three requesters: the CPU, the PPU, and an internal OAM DMA engine. Only one requester drives each bus at a time. The DMA engine is started through the DMA register at 0xFF46 and copies 160 bytes from {DMA,8'h00} into OAM. The CPU is locked out of VRAM and OAM according to the PPU mode and DMA activity. The block sits between the CPU memory map, the ppu, and the VRAM/OAM RAMs.

Parameters:
DMA_LEN, 160, number of bytes copied per DMA.
DMA_STARTUP, 4, idle clk cycles between the FF46 write and the first source read.
CYCLES_PER_BYTE, 4, clk cycles per copied byte; must be >= 2.

Ports:
clk  in  1  dot clock
rst  in  1  synchronous, active-high reset
lcd_on  in  1  LCDC[7]
ppu_mode  in  2  STAT[1:0] from the ppu
ppu_oam_a  in  16  PPU OAM read address
ppu_vram_a  in  16  PPU VRAM read address
cpu_a  in  16  CPU address
cpu_din  in  8  CPU write data
cpu_wr  in  1  CPU write strobe
cpu_rd  in  1  CPU read strobe
cpu_dout  out  8  CPU read data, valid the cycle after cpu_rd
oam_a  out  16  OAM address
oam_din  out  8  OAM write data
oam_wr  out  1  OAM write enable
oam_dout  in  8  OAM read data, 1-cycle latency
vram_a  out  16  VRAM address
vram_din  out  8  VRAM write data
vram_wr  out  1  VRAM write enable
vram_dout  in  8  VRAM read data, 1-cycle latency
dma_src_a  out  16  DMA source address
dma_src_rd  out  1  DMA source read strobe
dma_src_dout  in  8  source data, valid the cycle after dma_src_rd
dma_active  out  1  DMA in progress
dma_reg  out  8  current FF46 value

Behaviour:
- Reset values: dma_reg=0x00, dma_active=0, oam_wr=0, vram_wr=0, dma_src_rd=0, cpu_dout=0xFF, FSM=IDLE. A reset mid-DMA aborts the copy; no further OAM writes occur.
- CPU address decode:
  - VRAM hit: 0x8000-0x9FFF.
  - OAM hit: 0xFE00-0xFE9F.
  - Unused region 0xFEA0-0xFEFF: reads return 0xFF, writes are dropped.
  - 0xFF46: write loads dma_reg and starts DMA; read returns dma_reg.
- VRAM owner: PPU when lcd_on && ppu_mode==3, otherwise CPU.
- OAM owner, in priority order: DMA if dma_active; else PPU if lcd_on && ppu_mode is 2 or 3; else CPU.
- Bus mux outputs (*_a, *_din, *_wr) are combinational from the owner selection.
  - The bus carries the owner's address.
  - When the CPU owns a bus but is not accessing it: address=0xFFFF, wr=0.
  - PPU never writes: wr=0 while PPU owns.
- Blocked CPU access (target bus owned by PPU or DMA): write dropped, read returns 0xFF.
- cpu_dout is selected by a registered source tag captured on the cycle of cpu_rd: OAM/VRAM dout, dma_reg, or 0xFF. The tag defaults to 0xFF when there is no read.
- DMA FSM states: IDLE, START, COPY.
  - IDLE -> START: on a CPU write to 0xFF46 at cycle T; dma_active=1 from T+1.
  - START: lasts DMA_STARTUP cycles (T+1..T+DMA_STARTUP), then -> COPY with byte index i=0, sub-counter s=0.
  - COPY, s==0: dma_src_rd=1, dma_src_a={dma_reg, i[7:0]}.
  - COPY, s==1: oam_wr=1, oam_a=0xFE00+i, oam_din=dma_src_dout.
  - COPY, other s: OAM bus held by DMA at address 0xFE00+i with wr=0.
  - s wraps at CYCLES_PER_BYTE-1, then i increments.
  - After the write of byte DMA_LEN-1 -> IDLE; dma_active=0 on the next cycle.
- Default timing: byte0 read at T+5, byte0 write at T+6, byte159 write at T+642, dma_active falls at T+643.
- FF46 write during START or COPY: dma_reg is reloaded and the FSM restarts at START with i=0. dma_active stays 1 with no low gap. A byte write landing in the same cycle as the FF46 write still completes.
- DMA writes OAM regardless of lcd_on and ppu_mode. PPU OAM reads during DMA return whatever the OAM produces; this is accepted.
- The DMA source bus is external. Source-region contention with the CPU is resolved outside this block.
- Byte index width is 8 bits; DMA_LEN <= 256.

Test Plan:
- After reset, lcd_on=0, CPU writes 0x5A to 0x8010 then reads it -> vram_wr=1 at vram_a=0x8010; cpu_dout=0x5A the cycle after cpu_rd.
- lcd_on=1, ppu_mode=3: CPU reads 0x9000 and writes 0xFE00 -> cpu_dout=0xFF; vram_a follows ppu_vram_a; oam_wr=0. With ppu_mode=0 the same accesses succeed.
- CPU writes 0xC1 to 0xFF46 at cycle T, source returns i^0x33 -> dma_src_a=0xC100 at T+5; OAM write 0xFE00<=0x33 at T+6; 0xFE9F<=0xAC at T+642; dma_active low at T+643; FF46 reads 0xC1.
- During DMA, CPU reads 0xFE10 and writes 0xFE20 -> read returns 0xFF, write dropped. A CPU VRAM write with ppu_mode=0 still succeeds.
- FF46 rewritten with 0xD0 at byte 50 -> next source read at 0xD000 after 4 START cycles; dma_active never drops; 160 more writes occur.
- rst asserted mid-COPY -> dma_active=0, oam_wr=0, and dma_src_rd=0 on the next cycle, with no further writes.
